// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage that sits directly in front of a synchronous instruction ROM
//   with a 1-cycle registered read. It owns the program counter, keeps one
//   ROM read in flight, and delivers {pc, instruction} pairs to decode
//   through a 2-entry output buffer with a valid/ready handshake.
//   Issue credits are computed so that backpressure never drops or repeats
//   an instruction. A redirect squashes everything fetched but not yet
//   consumed, and restarts fetch at the new address.
//
// Ports:
//   clk         in   single clock, shared with the ROM
//   resetN      in   asynchronous active-low reset
//   romAddr     out  ROM word address (the fetchPc register itself)
//   romData     in   ROM read data for the address presented last cycle
//   instrValid  out  output buffer head is valid
//   instrReady  in   decode accepts the head this cycle
//   instr       out  head instruction word
//   pcOut       out  word address of the head instruction
//   redirect    in   flush and restart fetch at redirectPc
//   redirectPc  in   new fetch address, sampled while redirect=1
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     resetN,
  output logic [ADDRESS_WIDTH-1:0] romAddr,
  input  logic [DATA_WIDTH-1:0]    romData,
  output logic                     instrValid,
  input  logic                     instrReady,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pcOut,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirectPc
);

  logic [ADDRESS_WIDTH-1:0] fetchPc;
  logic [ADDRESS_WIDTH-1:0] inFlightPc;
  logic                     inFlight;

  // Output buffer: entry "head" is what decode sees, "tail" is the second slot.
  logic [1:0]               count;
  logic [ADDRESS_WIDTH-1:0] headPc;
  logic [ADDRESS_WIDTH-1:0] tailPc;
  logic [DATA_WIDTH-1:0]    headInstr;
  logic [DATA_WIDTH-1:0]    tailInstr;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] writeSlot;

  assign romAddr    = fetchPc;
  assign instrValid = (count != 2'd0);
  assign instr      = headInstr;
  assign pcOut      = headPc;

  // Handshake and credit decisions for this cycle. The occupancy term counts
  // the buffered entries plus the word still coming back from the ROM, minus
  // whatever decode takes now; a new read is only launched if that word is
  // guaranteed a free slot when it returns.
  always_comb begin
    pop       = instrValid && instrReady && !redirect;
    push      = inFlight && !redirect;
    occupancy = {1'b0, count} + {2'b00, inFlight} - {2'b00, pop};
    issue     = !redirect && (occupancy < 3'd2);
    writeSlot = count - {1'b0, pop};
  end

  // Program counter and the single outstanding ROM read. A redirect wins over
  // everything except reset and suppresses the issue in its own cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetchPc    <= ADDRESS_WIDTH'(RESET_PC);
      inFlight   <= 1'b0;
      inFlightPc <= '0;
    end else if (redirect) begin
      fetchPc  <= redirectPc;
      inFlight <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        inFlightPc <= fetchPc;
        fetchPc    <= fetchPc + ADDRESS_WIDTH'(1);
      end
    end
  end

  // Two-entry output buffer. A pop shifts the tail into the head; the
  // returning ROM word lands in the slot just past the surviving entries,
  // so when one entry is popped and one pushed with count=1 the new word
  // overrides the shift into the head.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count     <= 2'd0;
      headPc    <= '0;
      tailPc    <= '0;
      headInstr <= '0;
      tailInstr <= '0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        headPc    <= tailPc;
        headInstr <= tailInstr;
      end
      if (push) begin
        if (writeSlot == 2'd0) begin
          headPc    <= inFlightPc;
          headInstr <= romData;
        end else begin
          tailPc    <= inFlightPc;
          tailInstr <= romData;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The credit scheme must never let a ROM word arrive at a full buffer.
  overflowCheck: assert property (@(posedge clk) disable iff (!resetN)
    !(push && !pop && (count == 2'd2)));

endmodule
